stage_sequencer: RTL and testbench
==================================

# stage_sequencer

Game-side driver for the stage-clear checker. Holds the current level (1..5), publishes the 5-bit thermometer stage mask, and plays back a pseudo-random symbol sequence of that length. It then judges player button entries and emits one `true_stack` pulse per correct entry. It consumes the checker's `clear` / `allclear` to advance the level or declare a win; a wrong entry or timeout ends the game.

## Interface
Parameters:
- SHOW_CYCLES, 4, cycles each symbol is presented (show_valid high); must be ≥1
- GAP_CYCLES, 2, idle cycles after each presented symbol; must be ≥1
- TIMEOUT, 16, max cycles in WAIT_CLR before fail; must be ≥2

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high
- start  in  1  begin a new game (sampled in IDLE, WIN, LOSE only)
- btn_valid  in  1  one-cycle player entry strobe
- btn_sym  in  2  player symbol, valid with btn_valid
- clear  in  1  checker level-clear flag (level signal)
- allclear  in  1  checker final-level flag (level signal)
- stage  out  5  thermometer mask, level L → low L bits set
- true_stack  out  1  one-cycle pulse per correct entry
- show_valid  out  1  symbol presentation active
- show_sym  out  2  symbol being presented; 0 when show_valid low
- level  out  3  current level 0..5
- busy  out  1  high in LOAD/SHOW/PLAY/WAIT_CLR
- fail  out  1  high while in LOSE
- win  out  1  high while in WIN

## Operation
- LFSR: 10-bit, taps x^10+x^7+1, shifts every cycle including IDLE, reset value 10'h001; never reaches zero.
- Pattern: latched in LOAD as pat = lfsr; symbol i = pat[2i+1:2i], i=0..4; fixed for the whole game.
- States: IDLE, LOAD, SHOW, PLAY, WAIT_CLR, WIN, LOSE.
- IDLE/WIN/LOSE: start → LOAD; level←1, clears fail/win.
- LOAD (1 cycle): latch pattern → SHOW with sidx=0.
- SHOW: for sidx=0..level-1: SHOW_CYCLES cycles show_valid=1, show_sym=pat[sidx], then GAP_CYCLES cycles show_valid=0. After last gap → PLAY with pidx=0. btn_valid ignored.
- PLAY: on btn_valid, btn_sym==pat[pidx] → true_stack=1 next cycle, pidx++. If pidx reaches level → WAIT_CLR. Mismatch → LOSE, no true_stack.
- WAIT_CLR: rising edge of allclear → WIN. Else rising edge of clear → level++ → SHOW (sidx=0). Both rising on the same cycle → WIN. No edge within TIMEOUT cycles → LOSE. btn_valid ignored.
- Edge detect: clear_q/allclear_q registered every cycle; reset to 0.
- level increment saturates at 5; a clear edge at level 5 without allclear → LOSE (protocol error).
- stage = (1<<level)-1, registered; 5'b00000 at level 0.

## Timing
- Reset (async, any state): state IDLE, level 0, stage 0, true_stack 0, show_valid 0, show_sym 0, busy 0, fail 0, win 0, LFSR 10'h001, clear_q/allclear_q 0. Mid-game reset aborts immediately with no further pulses.
- All outputs are registered.
- start accepted at edge N → LOAD during N+1 → show_valid first high at N+2.
- SHOW duration = level×(SHOW_CYCLES+GAP_CYCLES) cycles.
- btn_valid at edge N (match) → true_stack high exactly cycle N+1; back-to-back btn_valid each produce a pulse.
- btn_valid coincident with the PLAY→WAIT_CLR transition edge is ignored.
- start while busy is ignored.

## Test plan
- Reset mid-SHOW at level 3 → all outputs 0 next cycle, state IDLE, stage=00000.
- start, level 1: one show_valid burst of 4 cycles, then correct btn_sym → one true_stack pulse; drive clear rising → level=2, stage=00011, SHOW replays 2 symbols identical to pat[1:0].
- Level 2: first entry correct, second wrong → exactly one true_stack, then fail=1, busy=0, win=0; start → level=1, fail=0.
- Full game with a checker model: five levels correct, allclear rising at level 5 → win=1, stage=11111, total true_stack pulses = 15.
- WAIT_CLR with clear held low for 16 cycles → fail=1; clear and allclear rising together → win=1.
- btn_valid during SHOW and WAIT_CLR → no true_stack, pidx unchanged; start during PLAY → no effect.

Source files
------------

// File: rtl/stage_sequencer.sv
// stage_sequencer: game-side driver for the stage-clear checker.
// It holds the current level, plays back a pseudo-random symbol sequence,
// judges player entries, and reacts to the checker's clear/allclear flags.
module stage_sequencer #(
    parameter int SHOW_CYCLES = 4,
    parameter int GAP_CYCLES  = 2,
    parameter int TIMEOUT     = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       btn_valid,
    input  logic [1:0] btn_sym,
    input  logic       clear,
    input  logic       allclear,
    output logic [4:0] stage,
    output logic       true_stack,
    output logic       show_valid,
    output logic [1:0] show_sym,
    output logic [2:0] level,
    output logic       busy,
    output logic       fail,
    output logic       win
);

    typedef enum logic [2:0] {
        IDLE, LOAD, SHOW, PLAY, WAIT_CLR, WIN, LOSE
    } state_t;

    localparam int CNT_MAX0 = (SHOW_CYCLES > GAP_CYCLES) ? SHOW_CYCLES : GAP_CYCLES;
    localparam int CNT_MAX  = (CNT_MAX0 > TIMEOUT) ? CNT_MAX0 : TIMEOUT;
    localparam int CW       = $clog2(CNT_MAX + 1);

    state_t          state_q;
    logic [9:0]      lfsr_q;
    logic [9:0]      lfsr_d;
    logic [9:0]      pat_q;
    logic            clear_q;
    logic            allclear_q;
    logic [2:0]      level_q;
    logic [4:0]      stage_q;
    logic            true_q;
    logic            show_valid_q;
    logic [1:0]      show_sym_q;
    logic            busy_q;
    logic            fail_q;
    logic            win_q;
    logic [2:0]      idx_q;
    logic            gap_q;
    logic [CW-1:0]   cnt_q;
    logic            clearRise;
    logic            allclearRise;

    // Thermometer mask for a level: level L sets the low L bits.
    function automatic logic [4:0] therm(input logic [2:0] l);
        case (l)
            3'd0:    therm = 5'b00000;
            3'd1:    therm = 5'b00001;
            3'd2:    therm = 5'b00011;
            3'd3:    therm = 5'b00111;
            3'd4:    therm = 5'b01111;
            default: therm = 5'b11111;
        endcase
    endfunction

    // Symbol i of the latched pattern lives in bits [2i+1:2i].
    function automatic logic [1:0] symAt(input logic [9:0] p, input logic [2:0] i);
        case (i)
            3'd0:    symAt = p[1:0];
            3'd1:    symAt = p[3:2];
            3'd2:    symAt = p[5:4];
            3'd3:    symAt = p[7:6];
            default: symAt = p[9:8];
        endcase
    endfunction

    assign lfsr_d       = {lfsr_q[8:0], lfsr_q[9] ^ lfsr_q[6]};
    assign clearRise    = clear & ~clear_q;
    assign allclearRise = allclear & ~allclear_q;

    // Game FSM: the LFSR and edge detectors run every cycle; all outputs are registered here.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            lfsr_q       <= 10'h001;
            pat_q        <= '0;
            clear_q      <= 1'b0;
            allclear_q   <= 1'b0;
            level_q      <= '0;
            stage_q      <= '0;
            true_q       <= 1'b0;
            show_valid_q <= 1'b0;
            show_sym_q   <= '0;
            busy_q       <= 1'b0;
            fail_q       <= 1'b0;
            win_q        <= 1'b0;
            idx_q        <= '0;
            gap_q        <= 1'b0;
            cnt_q        <= '0;
        end else begin
            lfsr_q     <= lfsr_d;
            clear_q    <= clear;
            allclear_q <= allclear;
            true_q     <= 1'b0;
            case (state_q)
                IDLE, WIN, LOSE: begin
                    if (start) begin
                        state_q <= LOAD;
                        level_q <= 3'd1;
                        stage_q <= therm(3'd1);
                        fail_q  <= 1'b0;
                        win_q   <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                LOAD: begin
                    pat_q        <= lfsr_q;
                    state_q      <= SHOW;
                    idx_q        <= '0;
                    cnt_q        <= '0;
                    gap_q        <= 1'b0;
                    show_valid_q <= 1'b1;
                    show_sym_q   <= lfsr_q[1:0];
                end
                SHOW: begin
                    if (!gap_q) begin
                        if (cnt_q == CW'(SHOW_CYCLES - 1)) begin
                            gap_q        <= 1'b1;
                            cnt_q        <= '0;
                            show_valid_q <= 1'b0;
                            show_sym_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end else if (cnt_q == CW'(GAP_CYCLES - 1)) begin
                        cnt_q <= '0;
                        if (idx_q == level_q - 3'd1) begin
                            state_q <= PLAY;
                            idx_q   <= '0;
                        end else begin
                            idx_q        <= idx_q + 3'd1;
                            gap_q        <= 1'b0;
                            show_valid_q <= 1'b1;
                            show_sym_q   <= symAt(pat_q, idx_q + 3'd1);
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                PLAY: begin
                    if (btn_valid) begin
                        if (btn_sym == symAt(pat_q, idx_q)) begin
                            true_q <= 1'b1;
                            if (idx_q + 3'd1 == level_q) begin
                                state_q <= WAIT_CLR;
                                idx_q   <= '0;
                                cnt_q   <= '0;
                            end else begin
                                idx_q <= idx_q + 3'd1;
                            end
                        end else begin
                            state_q <= LOSE;
                            fail_q  <= 1'b1;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                WAIT_CLR: begin
                    if (allclearRise) begin
                        state_q <= WIN;
                        win_q   <= 1'b1;
                        busy_q  <= 1'b0;
                    end else if (clearRise) begin
                        if (level_q == 3'd5) begin
                            state_q <= LOSE;
                            fail_q  <= 1'b1;
                            busy_q  <= 1'b0;
                        end else begin
                            level_q      <= level_q + 3'd1;
                            stage_q      <= therm(level_q + 3'd1);
                            state_q      <= SHOW;
                            idx_q        <= '0;
                            cnt_q        <= '0;
                            gap_q        <= 1'b0;
                            show_valid_q <= 1'b1;
                            show_sym_q   <= pat_q[1:0];
                        end
                    end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                        state_q <= LOSE;
                        fail_q  <= 1'b1;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign stage      = stage_q;
    assign true_stack = true_q;
    assign show_valid = show_valid_q;
    assign show_sym   = show_sym_q;
    assign level      = level_q;
    assign busy       = busy_q;
    assign fail       = fail_q;
    assign win        = win_q;

endmodule

// File: tb/tb_stage_sequencer.sv
// Testbench for stage_sequencer: directed game scenarios with a scoreboard
// that checks show bursts, true_stack pulses and status outputs.
module tb_stage_sequencer;

    localparam int SC   = 4;
    localparam int GC   = 2;
    localparam int TO   = 16;
    localparam int SLOT = SC + GC;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       btn_valid;
    logic [1:0] btn_sym;
    logic       clear;
    logic       allclear;
    logic [4:0] stage;
    logic       true_stack;
    logic       show_valid;
    logic [1:0] show_sym;
    logic [2:0] level;
    logic       busy;
    logic       fail;
    logic       win;

    typedef struct {
        int cyc;
        int kind;
        int lvl;
        int stg;
        int bsy;
        int fl;
        int wn;
    } stat_t;

    stat_t      statQ[$];
    int         showQ[$];
    int         trueQ[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         pulses = 0;
    int         pulseBase = 0;
    int         inBurst = 0;
    int         runLen = 0;
    int         curSym = 0;
    logic [9:0] lfsrM;
    logic [9:0] pat;

    stage_sequencer #(.SHOW_CYCLES(SC), .GAP_CYCLES(GC), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .start(start), .btn_valid(btn_valid),
        .btn_sym(btn_sym), .clear(clear), .allclear(allclear), .stage(stage),
        .true_stack(true_stack), .show_valid(show_valid), .show_sym(show_sym),
        .level(level), .busy(busy), .fail(fail), .win(win)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    // Cycle counter used to time-stamp expected events.
    always @(posedge clk) cyc <= cyc + 1;

    // Reference pattern generator: x^10+x^7+1 shifting every cycle from 10'h001.
    always @(posedge clk or posedge reset) begin
        if (reset) lfsrM <= 10'h001;
        else       lfsrM <= {lfsrM[8:0], lfsrM[9] ^ lfsrM[6]};
    end

    task automatic compareValue(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: actual %0d required %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops expectations and compares on the falling edge, away from the active edge.
    always @(negedge clk) begin
        stat_t s;
        while (statQ.size() > 0 && statQ[0].cyc <= cyc) begin
            s = statQ.pop_front();
            case (s.kind)
                0: begin
                    compareValue("level", int'(level), s.lvl);
                    compareValue("stage", int'(stage), s.stg);
                    compareValue("busy", int'(busy), s.bsy);
                    compareValue("fail", int'(fail), s.fl);
                    compareValue("win", int'(win), s.wn);
                end
                1: begin
                    compareValue("reset level", int'(level), 0);
                    compareValue("reset stage", int'(stage), 0);
                    compareValue("reset busy", int'(busy), 0);
                    compareValue("reset fail", int'(fail), 0);
                    compareValue("reset win", int'(win), 0);
                    compareValue("reset show_valid", int'(show_valid), 0);
                    compareValue("reset show_sym", int'(show_sym), 0);
                    compareValue("reset true_stack", int'(true_stack), 0);
                end
                2: compareValue("true_stack total", pulses - pulseBase, s.lvl);
                3: pulseBase = pulses;
                default: begin
                    compareValue("pending show bursts", showQ.size(), 0);
                    compareValue("pending true_stack", trueQ.size(), 0);
                end
            endcase
        end
        if (!reset) begin
            if (true_stack) begin
                pulses++;
                if (trueQ.size() == 0) compareValue("unexpected true_stack", 1, 0);
                else                   compareValue("true_stack cycle", cyc, trueQ.pop_front());
            end else if (trueQ.size() > 0 && trueQ[0] < cyc) begin
                compareValue("missing true_stack expected at cycle", 0, trueQ.pop_front());
            end
            if (show_valid) begin
                if (inBurst == 0) begin
                    if (showQ.size() == 0) begin
                        compareValue("unexpected show burst", 1, 0);
                        curSym = int'(show_sym);
                    end else begin
                        curSym = showQ.pop_front();
                    end
                    inBurst = 1;
                    runLen  = 0;
                end
                runLen++;
                compareValue("show_sym", int'(show_sym), curSym);
            end else begin
                if (inBurst != 0) begin
                    compareValue("show burst length", runLen, SC);
                    inBurst = 0;
                end
                compareValue("show_sym idle", int'(show_sym), 0);
            end
        end else begin
            inBurst = 0;
            runLen  = 0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic s, input logic bv, input logic [1:0] bs,
                                 input logic c, input logic ac);
        start     = s;
        btn_valid = bv;
        btn_sym   = bs;
        clear     = c;
        allclear  = ac;
        tick();
        start     = 1'b0;
        btn_valid = 1'b0;
        btn_sym   = 2'd0;
        clear     = 1'b0;
        allclear  = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
    endtask

    task automatic checkOutput(input int lvl, input int stg, input int bsy, input int fl, input int wn);
        statQ.push_back('{cyc, 0, lvl, stg, bsy, fl, wn});
    endtask

    task automatic pushKind(input int kind, input int val);
        statQ.push_back('{cyc, kind, val, 0, 0, 0, 0});
    endtask

    function automatic logic [1:0] symOf(input int i);
        return pat[2*i +: 2];
    endfunction

    task automatic pushShow(input int lvl);
        for (int i = 0; i < lvl; i++) showQ.push_back(int'(symOf(i)));
    endtask

    task automatic pressBtn(input logic [1:0] sym, input bit expectPulse);
        if (expectPulse) trueQ.push_back(cyc + 1);
        applyStimulus(1'b0, 1'b1, sym, 1'b0, 1'b0);
    endtask

    // Start a game and run until PLAY at level 1.
    task automatic startGame();
        applyStimulus(1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
        pat = lfsrM;
        pushShow(1);
        checkOutput(1, 5'b00001, 1, 0, 0);
        idle(1 + SLOT);
    endtask

    task automatic playLevel(input int lvl);
        for (int i = 0; i < lvl; i++) pressBtn(symOf(i), 1'b1);
    endtask

    // Clear rising edge: level advances, replay runs (a button press during it must be ignored).
    task automatic advance(input int newLvl);
        pushShow(newLvl);
        applyStimulus(1'b0, 1'b0, 2'd0, 1'b1, 1'b0);
        checkOutput(newLvl, (1 << newLvl) - 1, 1, 0, 0);
        pressBtn(symOf(0), 1'b0);
        idle(SLOT * newLvl - 1);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; btn_valid = 1'b0; btn_sym = 2'd0;
        clear = 1'b0; allclear = 1'b0;
        tick();
        tick();
        pushKind(1, 0);
        reset = 1'b0;
        tick();
        checkOutput(0, 0, 0, 0, 0);
        idle(3);

        // Level 1, then level 2 with a wrong second entry.
        startGame();
        playLevel(1);
        advance(2);
        pressBtn(symOf(0), 1'b1);
        pressBtn(symOf(1) ^ 2'b01, 1'b0);
        checkOutput(2, 5'b00011, 0, 1, 0);
        idle(2);

        // Full five-level game ending in allclear.
        pushKind(3, 0);
        startGame();
        playLevel(1);
        advance(2);
        playLevel(2);
        advance(3);
        applyStimulus(1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
        checkOutput(3, 5'b00111, 1, 0, 0);
        playLevel(3);
        pressBtn(symOf(0), 1'b0);
        advance(4);
        playLevel(4);
        advance(5);
        playLevel(5);
        applyStimulus(1'b0, 1'b0, 2'd0, 1'b0, 1'b1);
        checkOutput(5, 5'b11111, 0, 0, 1);
        pushKind(2, 15);
        idle(2);

        // Timeout in WAIT_CLR: still waiting after 15 cycles, lost after 16.
        startGame();
        playLevel(1);
        idle(TO - 1);
        checkOutput(1, 5'b00001, 1, 0, 0);
        idle(1);
        checkOutput(1, 5'b00001, 0, 1, 0);
        idle(2);

        // clear and allclear rising together wins.
        startGame();
        playLevel(1);
        applyStimulus(1'b0, 1'b0, 2'd0, 1'b1, 1'b1);
        checkOutput(1, 5'b00001, 0, 0, 1);
        idle(2);

        // Reset in the middle of the level-3 replay.
        startGame();
        playLevel(1);
        advance(2);
        playLevel(2);
        pushShow(3);
        applyStimulus(1'b0, 1'b0, 2'd0, 1'b1, 1'b0);
        idle(2);
        reset = 1'b1;
        showQ.delete();
        pushKind(1, 0);
        tick();
        pushKind(1, 0);
        reset = 1'b0;
        tick();
        checkOutput(0, 0, 0, 0, 0);
        idle(SLOT * 2);
        pushKind(4, 0);
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
